conv_controller: RTL and testbench

CONV_CONTROLLER -- requirements
Module: conv_controller

---
 rtl/conv_controller_if.sv | 35 +++
 rtl/conv_controller.sv | 149 ++++++++++++++
 tb/tb_conv_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/conv_controller_if.sv
// ============================================================================
// conv_controller_if : request/response bundle between the convolution
//                      datapath sequencer (master) and conv_controller (slave)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface conv_controller_if;
  logic       coeff_load_en;
  logic       sample_load_en;
  logic       new_row;
  logic       fifo_full;
  logic       modwait;
  logic [1:0] coeff_sel;
  logic       coeff_wr_en;
  logic       shift_en;
  logic       mac_clear;
  logic       mac_en;
  logic       fifo_push;
  logic       err;

  modport master (
    output coeff_load_en, sample_load_en, new_row, fifo_full,
    input  modwait, coeff_sel, coeff_wr_en, shift_en, mac_clear, mac_en,
           fifo_push, err
  );

  modport slave (
    input  coeff_load_en, sample_load_en, new_row, fifo_full,
    output modwait, coeff_sel, coeff_wr_en, shift_en, mac_clear, mac_en,
           fifo_push, err
  );
endinterface

`default_nettype wire

// File: rtl/conv_controller.sv
// ============================================================================
// conv_controller : sequences coefficient loads, sample-window shifts, 3-column
//                   MAC and result push for a 3-wide convolution datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_controller (
  input  wire logic           clk,
  input  wire logic           rst,
  conv_controller_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_COEFF = 3'd1,
    SHIFT      = 3'd2,
    MAC        = 3'd3,
    PUSH       = 3'd4
  } state_t;

  localparam logic [1:0] C_LAST_PHASE = 2'd2;
  localparam logic [1:0] C_COL_FULL   = 2'd3;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_phase;
  logic [1:0] w_phase_next;
  logic [1:0] r_col_cnt;
  logic [1:0] w_col_upd;
  logic       r_new_row;
  logic       r_err;
  logic       w_drop;
  logic       w_accept_sample;

  logic       w_modwait;
  logic [1:0] w_coeff_sel;
  logic       w_coeff_wr_en;
  logic       w_shift_en;
  logic       w_mac_clear;
  logic       w_mac_en;
  logic       w_fifo_push;

  // Coefficient requests win a same-cycle collision; the sample is the one lost.
  assign w_accept_sample = (r_state == IDLE) && bus.sample_load_en && !bus.coeff_load_en;

  assign w_drop = (r_state == IDLE) ? (bus.coeff_load_en && bus.sample_load_en)
                                    : (bus.coeff_load_en || bus.sample_load_en);

  // Window fill level after this SHIFT: restart at one column on a new row.
  assign w_col_upd = r_new_row                 ? 2'd1 :
                     (r_col_cnt == C_COL_FULL) ? C_COL_FULL :
                                                 r_col_cnt + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_phase   <= 2'd0;
      r_col_cnt <= 2'd0;
      r_new_row <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      if (w_accept_sample) begin
        r_new_row <= bus.new_row;
      end
      if (r_state == SHIFT) begin
        r_col_cnt <= w_col_upd;
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_phase_next  = 2'd0;
    w_modwait     = 1'b1;
    w_coeff_sel   = 2'd0;
    w_coeff_wr_en = 1'b0;
    w_shift_en    = 1'b0;
    w_mac_clear   = 1'b0;
    w_mac_en      = 1'b0;
    w_fifo_push   = 1'b0;

    case (r_state)
      IDLE: begin
        w_modwait = 1'b0;
        if (bus.coeff_load_en) begin
          w_state_next = LOAD_COEFF;
        end else if (bus.sample_load_en) begin
          w_state_next = SHIFT;
        end
      end

      LOAD_COEFF: begin
        w_coeff_wr_en = 1'b1;
        w_coeff_sel   = r_phase;
        if (r_phase == C_LAST_PHASE) begin
          w_state_next = IDLE;
        end else begin
          w_phase_next = r_phase + 2'd1;
        end
      end

      SHIFT: begin
        w_shift_en   = 1'b1;
        w_state_next = (w_col_upd == C_COL_FULL) ? MAC : IDLE;
      end

      MAC: begin
        w_mac_en    = 1'b1;
        w_mac_clear = (r_phase == 2'd0);
        w_coeff_sel = r_phase;
        if (r_phase == C_LAST_PHASE) begin
          w_state_next = PUSH;
        end else begin
          w_phase_next = r_phase + 2'd1;
        end
      end

      PUSH: begin
        // Hold here under backpressure; the push and the exit share a cycle.
        w_fifo_push = !bus.fifo_full;
        if (!bus.fifo_full) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.modwait     = w_modwait;
  assign bus.coeff_sel   = w_coeff_sel;
  assign bus.coeff_wr_en = w_coeff_wr_en;
  assign bus.shift_en    = w_shift_en;
  assign bus.mac_clear   = w_mac_clear;
  assign bus.mac_en      = w_mac_en;
  assign bus.fifo_push   = w_fifo_push;
  assign bus.err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_conv_controller.sv
// ============================================================================
// tb_conv_controller : directed + randomized bench for conv_controller, checked
//                      against a transaction-level schedule model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_controller;

  logic clk;
  logic rst;

  conv_controller_if bus ();

  conv_controller u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each accepted request expands into the list of busy cycles it costs.
  localparam logic [1:0] K_WR    = 2'd0;
  localparam logic [1:0] K_SHIFT = 2'd1;
  localparam logic [1:0] K_MAC   = 2'd2;
  localparam logic [1:0] K_PUSH  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] sel;
  } op_t;

  op_t q[$];
  int  m_cols;
  bit  m_err;
  bit  chk_on;
  int  errors;
  int  checks;

  function automatic logic [8:0] expected_vec(input logic ff);
    logic [8:0] v;
    v = {8'b0, m_err};
    if (q.size() != 0) begin
      v[8] = 1'b1;
      case (q[0].kind)
        K_WR:    begin v[7:6] = q[0].sel; v[5] = 1'b1; end
        K_SHIFT: v[4] = 1'b1;
        K_MAC:   begin v[7:6] = q[0].sel; v[2] = 1'b1; v[3] = (q[0].sel == 2'd0); end
        default: v[1] = !ff;
      endcase
    end
    return v;
  endfunction

  task automatic model_advance(input logic r, ce, se, nr, ff);
    if (r) begin
      q.delete();
      m_cols = 0;
      m_err  = 1'b0;
    end else if (q.size() != 0) begin
      if (ce || se) m_err = 1'b1;
      if (!(q[0].kind == K_PUSH && ff)) void'(q.pop_front());
    end else if (ce) begin
      for (int k = 0; k < 3; k++) q.push_back('{kind: K_WR, sel: 2'(k)});
      if (se) m_err = 1'b1;
    end else if (se) begin
      m_cols = nr ? 1 : ((m_cols + 1 > 3) ? 3 : m_cols + 1);
      q.push_back('{kind: K_SHIFT, sel: 2'd0});
      if (m_cols == 3) begin
        for (int k = 0; k < 3; k++) q.push_back('{kind: K_MAC, sel: 2'(k)});
        q.push_back('{kind: K_PUSH, sel: 2'd0});
      end
    end
  endtask

  task automatic step(input logic r, ce, se, nr, ff, input string tag);
    logic [8:0] obs;
    logic [8:0] exp_v;
    rst                = r;
    bus.coeff_load_en  = ce;
    bus.sample_load_en = se;
    bus.new_row        = nr;
    bus.fifo_full      = ff;
    @(negedge clk);
    if (chk_on) begin
      checks++;
      obs   = {bus.modwait, bus.coeff_sel, bus.coeff_wr_en, bus.shift_en,
               bus.mac_clear, bus.mac_en, bus.fifo_push, bus.err};
      exp_v = expected_vec(ff);
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed=%b expected=%b (modwait,sel,wr,shift,clr,mac,push,err)",
               tag, obs, exp_v);
      end
    end
    @(posedge clk);
    model_advance(r, ce, se, nr, ff);
    #1;
  endtask

  task automatic idle(input int n, input logic ff, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, ff, tag);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    chk_on = 1'b0;
    m_cols = 0;
    m_err  = 1'b0;
    rst    = 1'b1;
    bus.coeff_load_en  = 1'b0;
    bus.sample_load_en = 1'b0;
    bus.new_row        = 1'b0;
    bus.fifo_full      = 1'b0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_pre");
    chk_on = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold");
    idle(1, 1'b0, "reset_state");

    // Coefficient load
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "coeff_req");
    idle(3, 1'b0, "coeff_wr");
    idle(1, 1'b0, "coeff_done");

    // Row start: three columns needed before the first MAC
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "row_col1");
    idle(2, 1'b0, "row_shift1");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "row_col2");
    idle(2, 1'b0, "row_shift2");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "row_col3");
    idle(7, 1'b0, "row_mac_push");

    // Steady stream with saturated window
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "steady_col4");
    idle(6, 1'b0, "steady_mac_push");

    // Backpressure in PUSH
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "bp_sample");
    idle(4, 1'b0, "bp_shift_mac");
    idle(5, 1'b1, "bp_full");
    idle(1, 1'b0, "bp_release");
    idle(2, 1'b0, "bp_idle");

    // Collisions
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "col_sample");
    idle(2, 1'b0, "col_shift_mac0");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "col_sample_in_mac");
    idle(4, 1'b0, "col_mac_push");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "col_both_idle");
    idle(5, 1'b0, "col_coeff_err_sticky");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "col_good_traffic");
    idle(6, 1'b0, "col_err_stays");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "col_reset");
    idle(1, 1'b0, "col_err_cleared");

    // Coefficient reload mid-row keeps the window fill level
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "mid_col1");
    idle(2, 1'b0, "mid_shift1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mid_coeff");
    idle(4, 1'b0, "mid_coeff_wr");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mid_col2");
    idle(2, 1'b0, "mid_shift2");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mid_col3");
    idle(7, 1'b0, "mid_mac_push");

    // Reset during the second MAC cycle
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rmac_sample");
    idle(2, 1'b0, "rmac_shift_mac0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rmac_reset");
    idle(4, 1'b0, "rmac_after");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rmac_col_restart");
    idle(3, 1'b0, "rmac_no_mac");

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
